// File: rtl/uart_rx_mid.sv
// 8N1 UART receiver: three-flop synchroniser, mid-bit sampling, one-cycle
// po_flag on a good frame and one-cycle frame_err when the stop bit reads 0.
module uart_rx_mid #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned UART_BPS = 9600
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       rx,
    output logic [7:0] po_data,
    output logic       po_flag,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned       BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int unsigned       CNT_W        = $clog2(BAUD_CNT_MAX);
    localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(BAUD_CNT_MAX - 1);
    localparam logic [CNT_W-1:0]  SAMPLE_PT    = CNT_W'(BAUD_CNT_MAX / 2 - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           r_state;
    logic             r_rx_s1;
    logic             r_rx_s2;
    logic             r_rx_s3;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             w_start_edge;
    logic             w_sample;

    assign w_start_edge = r_rx_s3 & ~r_rx_s2;
    assign w_sample     = (r_baud_cnt == SAMPLE_PT);

    // Synchroniser resets to the idle level so release never looks like a start edge.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_s3 <= 1'b1;
        end else begin
            r_rx_s1 <= rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            po_data    <= '0;
            po_flag    <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            po_flag   <= 1'b0;
            frame_err <= 1'b0;

            if (r_state == IDLE || r_baud_cnt == CNT_LAST) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + 1'b1;
            end

            unique case (r_state)
                IDLE: begin
                    if (w_start_edge) begin
                        r_state <= START;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (w_sample) begin
                        if (r_rx_s2) begin
                            r_state <= IDLE;
                            busy    <= 1'b0;
                        end else begin
                            r_state   <= DATA;
                            r_bit_cnt <= '0;
                        end
                    end
                end
                DATA: begin
                    if (w_sample) begin
                        r_shift <= {r_rx_s2, r_shift[7:1]};
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    // Leave at mid stop bit so a start edge half a bit later is caught.
                    if (w_sample) begin
                        if (r_rx_s2) begin
                            po_data <= r_shift;
                            po_flag <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_mid.sv
// Bench for uart_rx_mid at 52 clocks per bit: a cycle-indexed line-history model
// checks every output every cycle; literal expectations pin each scenario.
module tb_uart_rx_mid;

    localparam int unsigned CLK_FREQ = 5_200_000;
    localparam int unsigned UART_BPS = 100_000;
    localparam int unsigned M        = 52;
    localparam int unsigned LAT      = 9 * M + M / 2 + 3;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       rx      = 1'b1;
    logic [7:0] po_data;
    logic       po_flag;
    logic       frame_err;
    logic       busy;

    uart_rx_mid #(
        .CLK_FREQ(CLK_FREQ),
        .UART_BPS(UART_BPS)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .rx       (rx),
        .po_data  (po_data),
        .po_flag  (po_flag),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #10 sys_clk = ~sys_clk;

    int unsigned cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Model: a frame starting with a fall at cycle n is sampled from the line history
    // at n+26+52k; the result shows up LAT cycles after the fall.
    logic        hist [0:65535];
    bit          act_f = 0;
    int unsigned n = 0, free_from = 0;
    int unsigned bf = 0, bu = 0, pf = 0, pu = 0;
    bit          ev_valid = 0, ev_good = 0;
    int unsigned ev_cyc = 0;
    logic [7:0]  sh = '0, ev_byte = '0, exp_data = '0;
    logic        e_flag, e_err, e_busy;

    int unsigned flag_cnt = 0, err_cnt = 0, last_flag_cyc = 0, busy_fall_cyc = 0;
    logic        prev_busy = 1'b0;
    logic [7:0]  got_q [$];

    always @(negedge sys_clk) begin
        int unsigned c, k;
        c = cyc;
        e_flag = 1'b0;
        e_err  = 1'b0;
        if (sys_rst) begin
            hist[c]   = 1'b1;
            act_f     = 0;
            ev_valid  = 0;
            bf = 0; bu = 0; pf = 0; pu = 0;
            free_from = 0;
            exp_data  = '0;
        end else begin
            hist[c] = rx;
            if (!act_f && c >= 1 && c >= free_from && hist[c-1] && !hist[c]) begin
                act_f = 1;
                n  = c;
                pf = bf;
                pu = bu;
                bf = c + 3;
                bu = 32'hFFFF_FFFF;
            end
            if (act_f && c >= n + M/2 && ((c - n - M/2) % M) == 0) begin
                k = (c - n - M/2) / M;
                if (k == 0) begin
                    if (hist[c]) begin
                        act_f = 0;
                        bu = n + M/2 + 3;
                        free_from = n + M/2 + 1;
                    end
                end else if (k <= 8) begin
                    sh[k-1] = hist[c];
                end else begin
                    act_f    = 0;
                    bu       = n + LAT;
                    free_from = n + LAT - 2;
                    ev_valid = 1;
                    ev_cyc   = n + LAT;
                    ev_good  = hist[c];
                    ev_byte  = sh;
                end
            end
            if (ev_valid && c == ev_cyc) begin
                e_flag = ev_good;
                e_err  = !ev_good;
                if (ev_good) exp_data = ev_byte;
                ev_valid = 0;
            end
        end
        e_busy = (c >= bf && c < bu) || (c >= pf && c < pu);
        check("cycle", {21'd0, busy, frame_err, po_flag, po_data},
              {21'd0, e_busy, e_err, e_flag, exp_data});

        if (po_flag) begin
            flag_cnt++;
            got_q.push_back(po_data);
            last_flag_cyc = c;
        end
        if (frame_err) err_cnt++;
        if (prev_busy && !busy) busy_fall_cyc = c;
        prev_busy = busy;
    end

    int unsigned fall_cyc;

    task automatic drive_bit(input logic v, input int unsigned len);
        rx = v;
        repeat (len) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int unsigned len);
        fall_cyc = cyc;
        drive_bit(1'b0, len);
        for (int i = 0; i < 8; i++) drive_bit(b[i], len);
        drive_bit(stop, len);
    endtask

    initial begin
        int unsigned f0, e0, n3;
        logic [7:0] skew_b [2];
        int unsigned skew_l [2];
        skew_b[0] = 8'hC5; skew_l[0] = 53;
        skew_b[1] = 8'h3A; skew_l[1] = 51;

        repeat (3) @(posedge sys_clk);
        #1;
        check("reset_outputs", {21'd0, busy, frame_err, po_flag, po_data}, 32'd0);
        sys_rst = 1'b0;
        drive_bit(1'b1, 10);

        // 1: single frame
        send_frame(8'h55, 1'b1, M);
        drive_bit(1'b1, 20);
        check("t1_flags", flag_cnt, 1);
        check("t1_errs", err_cnt, 0);
        check("t1_data", po_data, 8'h55);

        // 2: back-to-back frames
        got_q.delete();
        f0 = flag_cnt;
        for (int i = 0; i < 8; i++) send_frame(8'(i), 1'b1, M);
        drive_bit(1'b1, 20);
        check("t2_flags", flag_cnt - f0, 8);
        for (int i = 0; i < 8; i++) begin
            if (i < got_q.size()) check("t2_seq", got_q[i], i);
            else check("t2_seq_missing", 0, 1);
        end

        // 3: false start glitch, then valid frame
        f0 = flag_cnt; e0 = err_cnt;
        n3 = cyc;
        drive_bit(1'b0, 20);
        drive_bit(1'b1, 60);
        check("t3_no_flag", flag_cnt - f0, 0);
        check("t3_no_err", err_cnt - e0, 0);
        check("t3_busy_drop", busy_fall_cyc - n3, M/2 + 3);
        send_frame(8'hA3, 1'b1, M);
        drive_bit(1'b1, 20);
        check("t3_data", po_data, 8'hA3);

        // 4: framing error
        f0 = flag_cnt; e0 = err_cnt;
        send_frame(8'h3C, 1'b0, M);
        drive_bit(1'b1, 20);
        check("t4_err", err_cnt - e0, 1);
        check("t4_no_flag", flag_cnt - f0, 0);
        check("t4_data_held", po_data, 8'hA3);

        // 5: reset during data bit 4 of 0xFF
        f0 = flag_cnt; e0 = err_cnt;
        drive_bit(1'b0, M);
        repeat (4) drive_bit(1'b1, M);
        drive_bit(1'b1, 20);
        check("t5_busy_mid", busy, 1);
        sys_rst = 1'b1;
        drive_bit(1'b1, 3);
        check("t5_reset_outputs", {21'd0, busy, frame_err, po_flag, po_data}, 32'd0);
        sys_rst = 1'b0;
        drive_bit(1'b1, 6 * M);
        check("t5_no_pulse", (flag_cnt - f0) + (err_cnt - e0), 0);
        send_frame(8'h81, 1'b1, M);
        drive_bit(1'b1, 20);
        check("t5_data", po_data, 8'h81);

        // 6: latency and baud skew
        send_frame(8'h01, 1'b1, M);
        drive_bit(1'b1, 20);
        check("t6_latency", last_flag_cyc - fall_cyc, LAT);
        check("t6_data", po_data, 8'h01);
        for (int i = 0; i < 2; i++) begin
            send_frame(skew_b[i], 1'b1, skew_l[i]);
            drive_bit(1'b1, 30);
            check("t6_skew_data", po_data, skew_b[i]);
        end

        // Break: line held low, one error only
        e0 = err_cnt; f0 = flag_cnt;
        drive_bit(1'b0, 15 * M);
        drive_bit(1'b1, 30);
        check("break_err_once", err_cnt - e0, 1);
        check("break_no_flag", flag_cnt - f0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
